des_key_sched_ctrl: RTL and testbench

Sequential DES key-schedule controller. It takes a 56-bit post-PC-1 key and produces the 16 round keys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). A single 56-bit C/D register and one PC-2 permutation are reused for every round, instead of 16 unrolled per-round generators. It sits between key load and the iterative Feistel round engine, which consumes one round key per accepted transfer.

---
 rtl/des_pkg.sv | 35 +++
 rtl/p_box_56_48.sv | 27 ++
 rtl/des_key_sched_ctrl.sv | 109 ++++++++++
 tb/tb_des_key_sched_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths, shift schedule, state type and 28-bit rotate helpers for the DES key schedule
package des_pkg;

    localparam int KEY56_W = 56;
    localparam int RKEY_W  = 48;
    localparam int HALF_W  = 28;

    // Left-rotate amount per round, index 0 = round 1. Packed so element [r] is round r+1.
    localparam logic [15:0][1:0] SHIFT_SCHED = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    rotl28 = {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    rotl28 = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: rotl28 = x;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    rotr28 = {x[0], x[HALF_W-1:1]};
            2'd2:    rotr28 = {x[1:0], x[HALF_W-1:2]};
            default: rotr28 = x;
        endcase
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// rtl/p_box_56_48.sv - DES PC-2 permutation, 56-bit C||D to 48-bit round key
module p_box_56_48
    import des_pkg::*;
(
    input  logic [KEY56_W-1:0] cd_i,
    output logic [RKEY_W-1:0]  rkey_o
);

    // Standard PC-2 table, 1-based bit positions counted from the MSB of C||D.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Pure wiring: output bit i (from MSB) takes input position PC2_TAB[i].
    for (genvar i = 0; i < RKEY_W; i++) begin : g_pc2
        assign rkey_o[RKEY_W-1-i] = cd_i[KEY56_W - PC2_TAB[i]];
    end

    // Positions 9, 18, 22, 25, 35, 38, 43 and 54 are dropped by PC-2.
    logic pc2_unused;
    assign pc2_unused = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                          cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - sequential DES key schedule, one round key per handshake in either order
module des_key_sched_ctrl
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               decrypt,
    input  logic               abort,
    input  logic [KEY56_W-1:0] key_in,
    input  logic               key_ready,
    output logic               key_valid,
    output logic [RKEY_W-1:0]  round_key,
    output logic [3:0]         round_idx,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [KEY56_W-1:0] cd_q, cd_d;
    logic [3:0]         r_q, r_d;
    logic               dec_q, dec_d;
    logic               done_q, done_d;
    logic               accept;
    logic               last_key;

    function automatic logic [KEY56_W-1:0] rotl56(input logic [KEY56_W-1:0] x, input logic [1:0] n);
        rotl56 = {rotl28(x[KEY56_W-1:HALF_W], n), rotl28(x[HALF_W-1:0], n)};
    endfunction

    function automatic logic [KEY56_W-1:0] rotr56(input logic [KEY56_W-1:0] x, input logic [1:0] n);
        rotr56 = {rotr28(x[KEY56_W-1:HALF_W], n), rotr28(x[HALF_W-1:0], n)};
    endfunction

    assign accept   = (state_q == ST_RUN) && key_ready;
    assign last_key = dec_q ? (r_q == 4'd0) : (r_q == 4'd15);

    // State, C||D, round counter, latched direction and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            r_q     <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            r_q     <= r_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    // Next-state: abort wins over start and accept; a key only advances on accept.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        r_d     = r_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        dec_d   = decrypt;
                        if (decrypt) begin
                            // Total rotation over 16 rounds is 28, so C0D0 is already C16D16.
                            cd_d = key_in;
                            r_d  = 4'd15;
                        end else begin
                            cd_d = rotl56(key_in, SHIFT_SCHED[0]);
                            r_d  = 4'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_key) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (dec_q) begin
                            cd_d = rotr56(cd_q, SHIFT_SCHED[r_q]);
                            r_d  = r_q - 4'd1;
                        end else begin
                            cd_d = rotl56(cd_q, SHIFT_SCHED[r_q + 4'd1]);
                            r_d  = r_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    p_box_56_48 u_pc2 (
        .cd_i   (cd_q),
        .rkey_o (round_key)
    );

    assign key_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign round_idx = r_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb/tb_des_key_sched_ctrl.sv - directed self-checking bench for des_key_sched_ctrl
module tb_des_key_sched_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic        abort;
    logic [55:0] key_in;
    logic        key_ready;
    logic        key_valid;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    logic [47:0] kexp [16];

    des_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .decrypt   (decrypt),
        .abort     (abort),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_cmd(input logic dec);
        start   = 1'b1;
        decrypt = dec;
        tick();
        start   = 1'b0;
    endtask

    // Expects the first key of the schedule to be visible now; ends in the done cycle.
    task automatic run_full(input logic dec, input int max_stall, input int inject_at);
        for (int i = 0; i < 16; i++) begin
            int k;
            int ns;
            k  = dec ? 15 - i : i;
            ns = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            key_ready = 1'b0;
            for (int s = 0; s < ns; s++) begin
                chk("stall_valid", 64'(key_valid), 64'd1);
                chk("stall_key", 64'(round_key), 64'(kexp[k]));
                chk("stall_idx", 64'(round_idx), 64'(k));
                tick();
            end
            if (i == inject_at) begin
                start   = 1'b1;
                decrypt = ~dec;
            end
            key_ready = 1'b1;
            chk("valid", 64'(key_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_low", 64'(done), 64'd0);
            chk("key", 64'(round_key), 64'(kexp[k]));
            chk("idx", 64'(round_idx), 64'(k));
            tick();
            start   = 1'b0;
            decrypt = dec;
        end
        key_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(key_valid), 64'd0);
    endtask

    initial begin
        kexp = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        rst_n     = 1'b0;
        start     = 1'b0;
        decrypt   = 1'b0;
        abort     = 1'b0;
        key_ready = 1'b0;
        key_in    = 56'hF0CCAAF556678F;

        tick();
        tick();
        chk("rst_valid", 64'(key_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_key", 64'(round_key), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", 64'(key_valid), 64'd0);

        // Encrypt, ready held high
        start_cmd(1'b0);
        run_full(1'b0, 0, -1);
        tick();
        chk("done_single", 64'(done), 64'd0);

        // Decrypt, exact reverse order
        start_cmd(1'b1);
        run_full(1'b1, 0, -1);
        tick();

        // Backpressure with 0..5 stall cycles per key
        start_cmd(1'b0);
        run_full(1'b0, 5, -1);
        tick();

        // Abort after the 7th accept; abort asserted together with an accept
        start_cmd(1'b0);
        key_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("ab_idx", 64'(round_idx), 64'(i));
            chk("ab_key", 64'(round_key), 64'(kexp[i]));
            tick();
        end
        chk("ab_idx7", 64'(round_idx), 64'd7);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        key_ready = 1'b0;
        chk("ab_valid", 64'(key_valid), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        tick();
        chk("ab_done2", 64'(done), 64'd0);
        chk("ab_valid2", 64'(key_valid), 64'd0);
        start_cmd(1'b0);
        run_full(1'b0, 0, -1);
        tick();

        // start with toggled decrypt during RUN is ignored
        start_cmd(1'b0);
        run_full(1'b0, 2, 3);
        tick();

        // start together with abort in IDLE stays IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_valid", 64'(key_valid), 64'd0);
        chk("sa_busy", 64'(busy), 64'd0);
        tick();
        chk("sa_valid2", 64'(key_valid), 64'd0);

        // start in the done cycle gives K1 on the next cycle
        start_cmd(1'b1);
        run_full(1'b1, 0, -1);
        start_cmd(1'b0);
        run_full(1'b0, 0, -1);
        tick();

        // Asynchronous reset between clock edges mid-RUN
        start_cmd(1'b0);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_idx_pre", 64'(round_idx), 64'd4);
        key_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(key_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_key", 64'(round_key), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("ar_idle_valid", 64'(key_valid), 64'd0);
        chk("ar_idle_busy", 64'(busy), 64'd0);
        start_cmd(1'b0);
        run_full(1'b0, 0, -1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
